axilite_regfile: RTL and testbench
==================================

AXILITE_REGFILE -- requirements
Module: axilite_regfile

Interface
REQ-001 SHALL have parameter AW, default 64, AXI address width.
REQ-002 SHALL have parameter DW, default 64, AXI data width; legal values are 32 and 64.
REQ-003 SHALL have parameter NREG, default 16, number of DW-bit registers; SHALL be a power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have AW channel ports: axi_awaddr in AW; axi_awprot in 3 (ignored); axi_awvalid in 1; axi_awready out 1.
REQ-007 SHALL have W channel ports: axi_wdata in DW; axi_wstrb in DW/8; axi_wvalid in 1; axi_wready out 1.
REQ-008 SHALL have B channel ports: axi_bresp out 2; axi_bvalid out 1; axi_bready in 1.
REQ-009 SHALL have AR channel ports: axi_araddr in AW; axi_arprot in 3 (ignored); axi_arvalid in 1; axi_arready out 1.
REQ-010 SHALL have R channel ports: axi_rdata out DW; axi_rresp out 2; axi_rvalid out 1; axi_rready in 1.
REQ-011 SHALL have port reg_out, output, NREG*DW, flat register contents, register i at bits [i*DW +: DW].
REQ-012 SHALL have port reg_wr, output, NREG, one-cycle pulse per register on each committed OKAY write.

Function
REQ-013 SHALL decode by byte address: index = addr / (DW/8); low log2(DW/8) address bits are ignored.
REQ-014 SHALL treat addr >= NREG*DW/8 as out of range: write discarded, read data 0, response SLVERR (2'b10).
REQ-015 SHALL give in-range accesses response OKAY (2'b00).
REQ-016 SHALL hold AW and W in independent one-entry buffers; axi_awready = AW buffer empty; axi_wready = W buffer empty.
REQ-017 SHALL allow AW and W to arrive in either order or in the same cycle; a channel SHALL NOT accept a second beat until the pending write commits.
REQ-018 SHALL commit a write in the first cycle when both buffers are full and axi_bvalid=0; at commit, byte k of the target register is updated only where wstrb[k]=1.
REQ-019 SHALL, at commit, clear both buffers, drive reg_wr[index] high for that cycle (OKAY only), and register axi_bvalid=1 with bresp in the following cycle.
REQ-020 SHALL hold axi_bvalid and axi_bresp stable until axi_bready=1; bvalid clears the cycle after that handshake.
REQ-021 SHALL use write FSM states IDLE, HAVE_AW, HAVE_W, COMMIT, RESP: IDLE->HAVE_AW/HAVE_W/COMMIT as beats arrive; HAVE_x->COMMIT when the other beat arrives; COMMIT->RESP; RESP->IDLE on bready. Minimum write latency SHALL be 2 cycles from the later handshake to bvalid.
REQ-022 SHALL drive axi_arready = ~axi_rvalid; on an AR handshake, axi_rvalid=1 with rdata and rresp in the next cycle.
REQ-023 SHALL hold rvalid, rdata and rresp stable until axi_rready=1; a new AR SHALL NOT be accepted in the cycle of the R handshake.
REQ-024 SHALL, when an AR handshake coincides with a write commit to the same register, return the pre-write value.
REQ-025 SHALL operate the read and write paths fully concurrently with no mutual stalls.
REQ-026 SHALL drive reg_out combinationally from the register array, updating the cycle after commit.

Reset
REQ-027 SHALL, while reset=1, force all registers, reg_out and reg_wr to 0, axi_bvalid=0, axi_rvalid=0, bresp=rresp=2'b00, rdata=0, both buffers empty, and FSM=IDLE.
REQ-028 SHALL drive axi_awready, axi_wready and axi_arready to 0 while reset=1 and to 1 in the first cycle after deassertion.
REQ-029 SHALL, on reset asserted mid-transaction, discard buffered beats and pending responses with no partial write.

Structure
REQ-030 SHALL take AXI response codes (OKAY=2'b00, SLVERR=2'b10) and the write FSM state enum from shared package axilite_pkg.
REQ-031 SHALL place the AW/W join buffers and write FSM in sub-module axilite_regfile_wjoin; decode, register array and read path stay in the top.

Verification
REQ-032 SHALL cover: AW+W same cycle, addr 0x08, data 0x1122334455667788, strb 0xFF -> bvalid 2 cycles later, bresp 0, reg_wr[1] pulse, read of 0x08 returns 0x1122334455667788.
REQ-033 SHALL cover: W 3 cycles before AW, addr 0x10, strb 0x0F, data 0xFFFFFFFFFFFFFFFF over 0 -> reg 2 = 0x00000000FFFFFFFF.
REQ-034 SHALL cover: write and read of addr 0x80 (NREG=16, DW=64) -> SLVERR on B and R, rdata 0, no reg_wr, reg_out unchanged.
REQ-035 SHALL cover: bready held 0 for 10 cycles -> bvalid/bresp stable, awready/wready low once the next beats are buffered, no second commit.
REQ-036 SHALL cover: AR to reg 3 in the commit cycle of a write 0xAA to reg 3 that held 0x55 -> rdata 0x55; a later read returns 0xAA.
REQ-037 SHALL cover: reset pulsed with AW buffered and rvalid high -> all outputs at reset values, and a following write completes normally.

Source files
------------

// File: rtl/axilite_pkg.sv
// Shared AXI-Lite definitions: response codes, write-join FSM states and
// the helper that picks the next join state from the buffer occupancy.
package axilite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        HAVE_AW,
        HAVE_W,
        COMMIT,
        RESP
    } wstate_t;

    // Next waiting state given which halves of the write are buffered.
    function automatic wstate_t join_state(input logic aw_full, input logic w_full);
        if (aw_full && w_full) begin
            return COMMIT;
        end else if (aw_full) begin
            return HAVE_AW;
        end else if (w_full) begin
            return HAVE_W;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/axilite_regfile_wjoin.sv
// Joins the AXI-Lite AW and W channels through one-entry buffers, sequences
// the commit and owns the B channel response.
module axilite_regfile_wjoin
    import axilite_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [AW-1:0]   i_awaddr,
    input  logic            i_awvalid,
    output logic            o_awready,
    input  logic [DW-1:0]   i_wdata,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic            i_wvalid,
    output logic            o_wready,
    output logic [1:0]      o_bresp,
    output logic            o_bvalid,
    input  logic            i_bready,
    input  logic            i_slverr,
    output logic            o_commit,
    output logic [AW-1:0]   o_addr,
    output logic [DW-1:0]   o_wdata,
    output logic [DW/8-1:0] o_wstrb
);

    wstate_t          r_state;
    logic             r_aw_full;
    logic             r_w_full;
    logic [AW-1:0]    r_awaddr;
    logic [DW-1:0]    r_wdata;
    logic [DW/8-1:0]  r_wstrb;
    logic             r_bvalid;
    logic [1:0]       r_bresp;

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_aw_pend;
    logic             w_w_pend;

    // Ready is simply "buffer empty", held low while reset is asserted.
    assign o_awready = ~r_aw_full & ~i_reset;
    assign o_wready  = ~r_w_full & ~i_reset;
    assign w_aw_hs   = i_awvalid & o_awready;
    assign w_w_hs    = i_wvalid & o_wready;
    assign w_aw_pend = r_aw_full | w_aw_hs;
    assign w_w_pend  = r_w_full | w_w_hs;

    assign o_commit = (r_state == COMMIT);
    assign o_addr   = r_awaddr;
    assign o_wdata  = r_wdata;
    assign o_wstrb  = r_wstrb;
    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;

    // Buffer capture plus the join FSM; commit clears both buffers and raises bvalid.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_awaddr  <= i_awaddr;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
            end
            case (r_state)
                IDLE, HAVE_AW, HAVE_W: begin
                    r_state <= join_state(w_aw_pend, w_w_pend);
                end
                COMMIT: begin
                    r_aw_full <= 1'b0;
                    r_w_full  <= 1'b0;
                    r_bvalid  <= 1'b1;
                    r_bresp   <= i_slverr ? RESP_SLVERR : RESP_OKAY;
                    r_state   <= RESP;
                end
                RESP: begin
                    // Beats buffered while the response waited go straight on.
                    if (i_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= join_state(w_aw_pend, w_w_pend);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axilite_regfile.sv
// AXI-Lite slave register file: byte-addressed array of NREG DW-bit
// registers with strobed writes, SLVERR on out-of-range accesses and a
// flat view of every register for the surrounding logic.
module axilite_regfile
    import axilite_pkg::*;
#(
    parameter int AW   = 64,
    parameter int DW   = 64,
    parameter int NREG = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      axi_awaddr,
    input  logic [2:0]         axi_awprot,
    input  logic               axi_awvalid,
    output logic               axi_awready,
    input  logic [DW-1:0]      axi_wdata,
    input  logic [DW/8-1:0]    axi_wstrb,
    input  logic               axi_wvalid,
    output logic               axi_wready,
    output logic [1:0]         axi_bresp,
    output logic               axi_bvalid,
    input  logic               axi_bready,
    input  logic [AW-1:0]      axi_araddr,
    input  logic [2:0]         axi_arprot,
    input  logic               axi_arvalid,
    output logic               axi_arready,
    output logic [DW-1:0]      axi_rdata,
    output logic [1:0]         axi_rresp,
    output logic               axi_rvalid,
    input  logic               axi_rready,
    output logic [NREG*DW-1:0] reg_out,
    output logic [NREG-1:0]    reg_wr
);

    // BW byte-lane bits are dropped from the address, IW bits select the register.
    localparam int BW = $clog2(DW / 8);
    localparam int IW = $clog2(NREG);

    logic [DW-1:0]   r_regs [NREG];
    logic            r_rvalid;
    logic [DW-1:0]   r_rdata;
    logic [1:0]      r_rresp;

    logic            w_commit;
    logic [AW-1:0]   w_waddr;
    logic [DW-1:0]   w_wdata;
    logic [DW/8-1:0] w_wstrb;
    logic [IW-1:0]   w_wr_idx;
    logic            w_wr_oor;
    logic [IW-1:0]   w_rd_idx;
    logic            w_rd_oor;
    logic            w_ar_hs;
    logic            w_unused_ok;

    axilite_regfile_wjoin #(
        .AW (AW),
        .DW (DW)
    ) u_wjoin (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_awaddr  (axi_awaddr),
        .i_awvalid (axi_awvalid),
        .o_awready (axi_awready),
        .i_wdata   (axi_wdata),
        .i_wstrb   (axi_wstrb),
        .i_wvalid  (axi_wvalid),
        .o_wready  (axi_wready),
        .o_bresp   (axi_bresp),
        .o_bvalid  (axi_bvalid),
        .i_bready  (axi_bready),
        .i_slverr  (w_wr_oor),
        .o_commit  (w_commit),
        .o_addr    (w_waddr),
        .o_wdata   (w_wdata),
        .o_wstrb   (w_wstrb)
    );

    // Any set bit above the index field puts the address past the array.
    assign w_wr_idx = w_waddr[BW +: IW];
    assign w_wr_oor = |w_waddr[AW-1:BW+IW];
    assign w_rd_idx = axi_araddr[BW +: IW];
    assign w_rd_oor = |axi_araddr[AW-1:BW+IW];

    // A pending read response blocks the next AR, including its handshake cycle.
    assign axi_arready = ~r_rvalid & ~reset;
    assign w_ar_hs     = axi_arvalid & axi_arready;
    assign axi_rvalid  = r_rvalid;
    assign axi_rdata   = r_rdata;
    assign axi_rresp   = r_rresp;

    // Protection bits and byte-lane address bits carry no meaning here.
    assign w_unused_ok = ^{axi_awprot, axi_arprot, w_waddr[BW-1:0], axi_araddr[BW-1:0]};

    // Per-register write pulse during the commit cycle of an in-range write.
    always_comb begin
        reg_wr = '0;
        if (w_commit && !w_wr_oor) begin
            reg_wr[w_wr_idx] = 1'b1;
        end
    end

    // Strobed byte update of the target register at commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && !w_wr_oor) begin
            for (int k = 0; k < DW / 8; k++) begin
                if (w_wstrb[k]) begin
                    r_regs[w_wr_idx][k*8 +: 8] <= w_wdata[k*8 +: 8];
                end
            end
        end
    end

    // Read response capture; sampling before the write lands returns pre-write data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_oor ? '0 : r_regs[w_rd_idx];
            r_rresp  <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (r_rvalid && axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // Flat register view for the surrounding logic.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_out
        assign reg_out[gi*DW +: DW] = r_regs[gi];
    end

endmodule

// File: tb/tb_axilite_regfile.sv
// Directed bench for axilite_regfile: expected B/R responses are queued as
// stimulus is issued and a negedge monitor checks them on each handshake.
module tb_axilite_regfile;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int NREG = 16;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [AW-1:0]      axi_awaddr;
    logic [2:0]         axi_awprot;
    logic               axi_awvalid;
    logic               axi_awready;
    logic [DW-1:0]      axi_wdata;
    logic [DW/8-1:0]    axi_wstrb;
    logic               axi_wvalid;
    logic               axi_wready;
    logic [1:0]         axi_bresp;
    logic               axi_bvalid;
    logic               axi_bready;
    logic [AW-1:0]      axi_araddr;
    logic [2:0]         axi_arprot;
    logic               axi_arvalid;
    logic               axi_arready;
    logic [DW-1:0]      axi_rdata;
    logic [1:0]         axi_rresp;
    logic               axi_rvalid;
    logic               axi_rready;
    logic [NREG*DW-1:0] reg_out;
    logic [NREG-1:0]    reg_wr;

    logic [1:0]  bq[$];
    rexp_t       rq[$];
    rexp_t       r_e;
    logic [63:0] model [NREG];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    axilite_regfile #(
        .AW   (AW),
        .DW   (DW),
        .NREG (NREG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .axi_awaddr  (axi_awaddr),
        .axi_awprot  (axi_awprot),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arprot  (axi_arprot),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .reg_out     (reg_out),
        .reg_wr      (reg_wr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NREG; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), reg_out[i*DW +: DW], model[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for every queued response to be observed.
    task automatic wait_resp();
        for (int i = 0; i < 40; i++) begin
            if (bq.size() == 0 && rq.size() == 0) break;
            step();
        end
        if (bq.size() != 0 || rq.size() != 0) begin
            n_checks++;
            $display("FAIL resp_timeout: got %0d pending required 0", bq.size() + rq.size());
            bq.delete();
            rq.delete();
        end
    endtask

    task automatic wr(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
        axi_awaddr  = addr;
        axi_wdata   = data;
        axi_wstrb   = strb;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        for (int i = 0; i < 20 && !(axi_awready && axi_wready); i++) step();
        if (!(axi_awready && axi_wready)) begin
            n_checks++;
            $display("FAIL wr_ready_timeout: got 0 required 1");
        end
        step();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
    endtask

    task automatic rd(input logic [63:0] addr, input logic [63:0] exp_d, input logic [1:0] exp_r);
        rexp_t e;
        e.data = exp_d;
        e.resp = exp_r;
        rq.push_back(e);
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        for (int i = 0; i < 20 && !axi_arready; i++) step();
        if (!axi_arready) begin
            n_checks++;
            $display("FAIL rd_arready_timeout: got 0 required 1");
        end
        step();
        axi_arvalid = 1'b0;
        wait_resp();
    endtask

    // Scoreboard monitor: compare B and R beats against the queued expectations.
    always @(negedge clk) begin
        if (!reset && axi_bvalid && axi_bready) begin
            if (bq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_b: got bresp %0h required no response", axi_bresp);
            end else begin
                chk("bresp", 64'(axi_bresp), 64'(bq.pop_front()));
            end
        end
        if (!reset && axi_rvalid && axi_rready) begin
            if (rq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_r: got rdata %0h required no response", axi_rdata);
            end else begin
                r_e = rq.pop_front();
                chk("rdata", axi_rdata, r_e.data);
                chk("rresp", 64'(axi_rresp), 64'(r_e.resp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        axi_awaddr  = '0;
        axi_awprot  = 3'b000;
        axi_awvalid = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b1;
        axi_araddr  = '0;
        axi_arprot  = 3'b000;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b1;
        for (int i = 0; i < NREG; i++) model[i] = 64'h0;
        step();
        step();

        // Reset state
        chk("rst_awready", 64'(axi_awready), 64'h0);
        chk("rst_wready", 64'(axi_wready), 64'h0);
        chk("rst_arready", 64'(axi_arready), 64'h0);
        chk("rst_bvalid", 64'(axi_bvalid), 64'h0);
        chk("rst_rvalid", 64'(axi_rvalid), 64'h0);
        chk("rst_rdata", axi_rdata, 64'h0);
        chk("rst_reg_wr", 64'(reg_wr), 64'h0);
        chk_regs("rst");
        reset = 1'b0;
        #1;
        chk("post_rst_awready", 64'(axi_awready), 64'h1);
        chk("post_rst_wready", 64'(axi_wready), 64'h1);
        chk("post_rst_arready", 64'(axi_arready), 64'h1);

        // AW and W in the same cycle, full-width write to register 1
        axi_awaddr  = 64'h08;
        axi_wdata   = 64'h1122334455667788;
        axi_wstrb   = 8'hFF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        bq.push_back(2'b00);
        step();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        chk("s1_reg_wr_commit", 64'(reg_wr), 64'h0002);
        chk("s1_bvalid_cyc1", 64'(axi_bvalid), 64'h0);
        step();
        chk("s1_bvalid_cyc2", 64'(axi_bvalid), 64'h1);
        chk("s1_reg_wr_after", 64'(reg_wr), 64'h0);
        model[1] = 64'h1122334455667788;
        chk_regs("s1");
        wait_resp();
        rd(64'h08, 64'h1122334455667788, 2'b00);

        // W three cycles ahead of AW, low-half strobe into register 2
        axi_wdata  = 64'hFFFFFFFFFFFFFFFF;
        axi_wstrb  = 8'h0F;
        axi_wvalid = 1'b1;
        step();
        axi_wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("s2_wready_held", 64'(axi_wready), 64'h0);
            chk("s2_awready_open", 64'(axi_awready), 64'h1);
            chk("s2_no_bvalid", 64'(axi_bvalid), 64'h0);
            step();
        end
        axi_awaddr  = 64'h10;
        axi_awvalid = 1'b1;
        bq.push_back(2'b00);
        step();
        axi_awvalid = 1'b0;
        chk("s2_reg_wr_commit", 64'(reg_wr), 64'h0004);
        step();
        model[2] = 64'h00000000FFFFFFFF;
        chk_regs("s2");
        wait_resp();

        // Out-of-range write and read
        axi_awaddr  = 64'h80;
        axi_wdata   = 64'hDEADBEEFDEADBEEF;
        axi_wstrb   = 8'hFF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        bq.push_back(2'b10);
        step();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        chk("s3_reg_wr_commit", 64'(reg_wr), 64'h0);
        step();
        chk("s3_reg_wr_after", 64'(reg_wr), 64'h0);
        chk_regs("s3");
        wait_resp();
        rd(64'h80, 64'h0, 2'b10);

        // Back-pressure on B while the next write is buffered
        axi_bready  = 1'b0;
        axi_awaddr  = 64'h20;
        axi_wdata   = 64'h0123456789ABCDEF;
        axi_wstrb   = 8'hFF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        bq.push_back(2'b00);
        step();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        step();
        axi_awaddr  = 64'h28;
        axi_wdata   = 64'hCAFEF00D12345678;
        axi_wstrb   = 8'hF0;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        step();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("s4_bvalid_hold", 64'(axi_bvalid), 64'h1);
            chk("s4_bresp_hold", 64'(axi_bresp), 64'h0);
            chk("s4_awready_low", 64'(axi_awready), 64'h0);
            chk("s4_wready_low", 64'(axi_wready), 64'h0);
            chk("s4_no_commit", 64'(reg_wr), 64'h0);
            step();
        end
        model[4] = 64'h0123456789ABCDEF;
        chk_regs("s4_held");
        bq.push_back(2'b00);
        axi_bready = 1'b1;
        step();
        chk("s4_reg_wr_second", 64'(reg_wr), 64'h0020);
        chk("s4_bvalid_gap", 64'(axi_bvalid), 64'h0);
        step();
        chk("s4_bvalid_second", 64'(axi_bvalid), 64'h1);
        model[5] = 64'hCAFEF00D00000000;
        chk_regs("s4");
        wait_resp();

        // Read colliding with a commit to the same register returns the old value
        bq.push_back(2'b00);
        wr(64'h18, 64'h55, 8'hFF);
        wait_resp();
        model[3] = 64'h55;
        axi_awaddr  = 64'h18;
        axi_wdata   = 64'hAA;
        axi_wstrb   = 8'hFF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        bq.push_back(2'b00);
        step();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        chk("s5_reg_wr_commit", 64'(reg_wr), 64'h0008);
        chk("s5_arready", 64'(axi_arready), 64'h1);
        axi_araddr  = 64'h18;
        axi_arvalid = 1'b1;
        r_e.data = 64'h55;
        r_e.resp = 2'b00;
        rq.push_back(r_e);
        step();
        axi_arvalid = 1'b0;
        model[3] = 64'hAA;
        wait_resp();
        rd(64'h18, 64'hAA, 2'b00);

        // Reset in the middle of a buffered AW and a pending read response
        axi_awaddr  = 64'h30;
        axi_awvalid = 1'b1;
        step();
        axi_awvalid = 1'b0;
        chk("s6_aw_buffered", 64'(axi_awready), 64'h0);
        axi_rready  = 1'b0;
        axi_araddr  = 64'h08;
        axi_arvalid = 1'b1;
        step();
        axi_arvalid = 1'b0;
        chk("s6_rvalid_pending", 64'(axi_rvalid), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("s6_rst_awready", 64'(axi_awready), 64'h0);
        chk("s6_rst_wready", 64'(axi_wready), 64'h0);
        chk("s6_rst_arready", 64'(axi_arready), 64'h0);
        chk("s6_rst_bvalid", 64'(axi_bvalid), 64'h0);
        chk("s6_rst_bresp", 64'(axi_bresp), 64'h0);
        chk("s6_rst_rvalid", 64'(axi_rvalid), 64'h0);
        chk("s6_rst_rdata", axi_rdata, 64'h0);
        chk("s6_rst_rresp", 64'(axi_rresp), 64'h0);
        chk("s6_rst_reg_wr", 64'(reg_wr), 64'h0);
        for (int i = 0; i < NREG; i++) model[i] = 64'h0;
        chk_regs("s6_rst");
        step();
        step();
        reset      = 1'b0;
        axi_rready = 1'b1;
        #1;
        chk("s6_post_awready", 64'(axi_awready), 64'h1);
        chk("s6_post_wready", 64'(axi_wready), 64'h1);
        chk("s6_post_arready", 64'(axi_arready), 64'h1);
        axi_wdata  = 64'h77;
        axi_wstrb  = 8'hFF;
        axi_wvalid = 1'b1;
        step();
        axi_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("s6_no_stale_bvalid", 64'(axi_bvalid), 64'h0);
            chk("s6_no_stale_commit", 64'(reg_wr), 64'h0);
            step();
        end
        chk_regs("s6_nowrite");
        axi_awaddr  = 64'h30;
        axi_awvalid = 1'b1;
        bq.push_back(2'b00);
        step();
        axi_awvalid = 1'b0;
        chk("s6_reg_wr_commit", 64'(reg_wr), 64'h0040);
        step();
        model[6] = 64'h77;
        chk_regs("s6");
        wait_resp();
        rd(64'h30, 64'h77, 2'b00);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
